// File: rtl/one_vertex_avg.sv
// Pipelined single-vertex trilateration: intersect circles U and V, keep the point
// inside circle W, optionally average 2^LOG_AVG consecutive vertices before output.

module intersections #(
  parameter int N = 8
) (
  input  logic signed [N-1:0] xu,
  input  logic signed [N-1:0] yu,
  input  logic signed [N-1:0] xv,
  input  logic signed [N-1:0] yv,
  input  logic signed [N:0]   ru,
  input  logic signed [N:0]   rv,
  output logic signed [N+1:0] x1,
  output logic signed [N+1:0] y1,
  output logic signed [N+1:0] x2,
  output logic signed [N+1:0] y2
);
  localparam int M = 4*N + 12;
  localparam int H = M / 2;

  function automatic logic [H-1:0] isqrt(input logic [M-1:0] v);
    logic [H-1:0] res;
    logic [H-1:0] cand;
    logic [M-1:0] sq;
    res = '0;
    for (int i = H - 1; i >= 0; i--) begin
      cand    = res;
      cand[i] = 1'b1;
      sq      = {{(M-H){1'b0}}, cand} * {{(M-H){1'b0}}, cand};
      if (sq <= v) res = cand;
    end
    return res;
  endfunction

  logic signed [M-1:0] dx, dy, d2, ru2, rv2, k, disc, s, den;
  logic signed [M-1:0] nx1, ny1, nx2, ny2;

  // P = U + (k*d -/+ s*perp(d)) / (2*|d|^2), s = sqrt(4|d|^2 rU^2 - k^2); P1 lies left of U->V.
  always_comb begin
    dx   = M'(xv) - M'(xu);
    dy   = M'(yv) - M'(yu);
    d2   = dx*dx + dy*dy;
    ru2  = M'(ru) * M'(ru);
    rv2  = M'(rv) * M'(rv);
    k    = ru2 - rv2 + d2;
    disc = ((d2 * ru2) <<< 2) - k*k;
    s    = (disc > 0) ? $signed({{(M-H){1'b0}}, isqrt(disc)}) : '0;
    // coincident anchors give zero numerators, so both points collapse onto U
    den  = (d2 == 0) ? M'(1) : (d2 <<< 1);
    nx1  = k*dx - dy*s;
    ny1  = k*dy + dx*s;
    nx2  = k*dx + dy*s;
    ny2  = k*dy - dx*s;
    x1   = (N+2)'(M'(xu) + nx1 / den);
    y1   = (N+2)'(M'(yu) + ny1 / den);
    x2   = (N+2)'(M'(xu) + nx2 / den);
    y2   = (N+2)'(M'(yu) + ny2 / den);
  end
endmodule

module inside_ #(
  parameter int N = 8
) (
  input  logic signed [N+1:0] x,
  input  logic signed [N+1:0] y,
  input  logic signed [N-1:0] xc,
  input  logic signed [N-1:0] yc,
  input  logic signed [N:0]   r,
  output logic                hit
);
  localparam int Q = 2*N + 8;
  logic signed [Q-1:0] ex, ey, d2, r2;

  // boundary counts as inside
  always_comb begin
    ex  = Q'(x) - Q'(xc);
    ey  = Q'(y) - Q'(yc);
    d2  = ex*ex + ey*ey;
    r2  = Q'(r) * Q'(r);
    hit = (d2 <= r2);
  end
endmodule

module one_vertex_avg #(
  parameter int N       = 8,
  parameter int LOG_AVG = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [N-1:0] xU,
  input  logic signed [N-1:0] yU,
  input  logic signed [N-1:0] xV,
  input  logic signed [N-1:0] yV,
  input  logic signed [N-1:0] xW,
  input  logic signed [N-1:0] yW,
  input  logic signed [N:0]   rU,
  input  logic signed [N:0]   rV,
  input  logic signed [N:0]   rW,
  input  logic               avg_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [N+1:0] xT,
  output logic signed [N+1:0] yT,
  output logic               amb,
  output logic               miss
);
  localparam int AW = N + 2 + LOG_AVG;

  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  logic s1_valid, s2_valid, s3_valid;
  logic signed [N-1:0] s1_xu, s1_yu, s1_xv, s1_yv, s1_xw, s1_yw;
  logic signed [N:0]   s1_ru, s1_rv, s1_rw;
  logic                s1_avg;

  logic signed [N+1:0] p1_x, p1_y, p2_x, p2_y;
  logic signed [N+1:0] s2_x1, s2_y1, s2_x2, s2_y2;
  logic signed [N-1:0] s2_xw, s2_yw;
  logic signed [N:0]   s2_rw;
  logic                s2_avg;

  logic                in1, in2;
  logic signed [N+1:0] s3_x, s3_y;
  logic                s3_amb_f, s3_miss_f, s3_avg;

  logic signed [AW-1:0] acc_x, acc_y, sum_x, sum_y;
  logic [LOG_AVG-1:0]   cnt;
  logic                 amb_acc, miss_acc;

  intersections #(.N(N)) u_intersections (
    .xu(s1_xu), .yu(s1_yu), .xv(s1_xv), .yv(s1_yv), .ru(s1_ru), .rv(s1_rv),
    .x1(p1_x), .y1(p1_y), .x2(p2_x), .y2(p2_y)
  );

  inside_ #(.N(N)) u_inside1 (
    .x(s2_x1), .y(s2_y1), .xc(s2_xw), .yc(s2_yw), .r(s2_rw), .hit(in1)
  );

  inside_ #(.N(N)) u_inside2 (
    .x(s2_x2), .y(s2_y2), .xc(s2_xw), .yc(s2_yw), .r(s2_rw), .hit(in2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
    end
  end

  // datapath registers carry no reset; the valid bits qualify them
  always_ff @(posedge clk) begin
    if (!stall) begin
      s1_xu  <= xU;   s1_yu <= yU;
      s1_xv  <= xV;   s1_yv <= yV;
      s1_xw  <= xW;   s1_yw <= yW;
      s1_ru  <= rU;   s1_rv <= rV;   s1_rw <= rW;
      s1_avg <= avg_en;

      s2_x1  <= p1_x; s2_y1 <= p1_y;
      s2_x2  <= p2_x; s2_y2 <= p2_y;
      s2_xw  <= s1_xw; s2_yw <= s1_yw; s2_rw <= s1_rw;
      s2_avg <= s1_avg;

      s3_x      <= in2 ? s2_x2 : s2_x1;
      s3_y      <= in2 ? s2_y2 : s2_y1;
      s3_amb_f  <= in1 && in2;
      s3_miss_f <= !in1 && !in2;
      s3_avg    <= s2_avg;
    end
  end

  assign sum_x = acc_x + {{LOG_AVG{s3_x[N+1]}}, s3_x};
  assign sum_y = acc_y + {{LOG_AVG{s3_y[N+1]}}, s3_y};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      xT        <= '0;
      yT        <= '0;
      amb       <= 1'b0;
      miss      <= 1'b0;
      acc_x     <= '0;
      acc_y     <= '0;
      cnt       <= '0;
      amb_acc   <= 1'b0;
      miss_acc  <= 1'b0;
    end else if (!stall) begin
      // not stalled: any held result is being consumed this edge
      out_valid <= 1'b0;
      if (s3_valid) begin
        if (!s3_avg) begin
          xT        <= s3_x;
          yT        <= s3_y;
          amb       <= s3_amb_f;
          miss      <= s3_miss_f;
          out_valid <= 1'b1;
          acc_x     <= '0;
          acc_y     <= '0;
          cnt       <= '0;
          amb_acc   <= 1'b0;
          miss_acc  <= 1'b0;
        end else if (cnt != '1) begin
          acc_x    <= sum_x;
          acc_y    <= sum_y;
          cnt      <= cnt + 1'b1;
          amb_acc  <= amb_acc | s3_amb_f;
          miss_acc <= miss_acc | s3_miss_f;
        end else begin
          // arithmetic shift right then truncate == picking bits above LOG_AVG
          xT        <= sum_x[LOG_AVG +: N+2];
          yT        <= sum_y[LOG_AVG +: N+2];
          amb       <= amb_acc | s3_amb_f;
          miss      <= miss_acc | s3_miss_f;
          out_valid <= 1'b1;
          acc_x     <= '0;
          acc_y     <= '0;
          cnt       <= '0;
          amb_acc   <= 1'b0;
          miss_acc  <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_one_vertex_avg.sv
// Scoreboard bench for one_vertex_avg: geometric reference model, random and directed frames.

module tb_one_vertex_avg;
  localparam int N       = 8;
  localparam int LOG_AVG = 2;
  localparam int WIN     = 1 << LOG_AVG;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, avg_en, out_valid, out_ready, amb, miss;
  logic signed [N-1:0] xU, yU, xV, yV, xW, yW;
  logic signed [N:0]   rU, rV, rW;
  logic signed [N+1:0] xT, yT;

  always #5 clk = ~clk;

  one_vertex_avg #(.N(N), .LOG_AVG(LOG_AVG)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .xU(xU), .yU(yU), .xV(xV), .yV(yV), .xW(xW), .yW(yW),
    .rU(rU), .rV(rV), .rW(rW), .avg_en(avg_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .xT(xT), .yT(yT), .amb(amb), .miss(miss)
  );

  typedef struct {
    int xu, yu, xv, yv, ru, rv, xw, yw, rw;
    bit avg;
    int ex, ey;
    bit amb, miss;
  } frame_t;

  typedef struct {
    int x, y;
    bit amb, miss;
  } res_t;

  res_t exp_q[$];
  res_t win[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;
  bit   rand_ready = 1'b0;

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  function automatic int floor_div(input int s, input int n);
    return (s >= 0) ? s / n : -((-s + n - 1) / n);
  endfunction

  function automatic frame_t mk(input int xu, yu, xv, yv, ru, rv, xw, yw, rw,
                                input bit avg, input int ex, ey, input bit a, m);
    frame_t f;
    f.xu = xu; f.yu = yu; f.xv = xv; f.yv = yv;
    f.ru = ru; f.rv = rv; f.xw = xw; f.yw = yw; f.rw = rw;
    f.avg = avg; f.ex = ex; f.ey = ey; f.amb = a; f.miss = m;
    return f;
  endfunction

  // Build a geometry from a Pythagorean triple so both intersections are exact integers.
  function automatic frame_t rnd_frame(input bit avg);
    frame_t f;
    int a, b, r, dxh, dyh, ux, uy, mx, my, p1x, p1y, p2x, p2y;
    case ($urandom_range(0, 7))
      0: begin a = 3;  b = 4;  r = 5;  end
      1: begin a = 4;  b = 3;  r = 5;  end
      2: begin a = 6;  b = 8;  r = 10; end
      3: begin a = 8;  b = 6;  r = 10; end
      4: begin a = 5;  b = 12; r = 13; end
      5: begin a = 12; b = 5;  r = 13; end
      6: begin a = 8;  b = 15; r = 17; end
      default: begin a = 15; b = 8; r = 17; end
    endcase
    case ($urandom_range(0, 3))
      0: begin dxh = 1;  dyh = 0;  end
      1: begin dxh = 0;  dyh = 1;  end
      2: begin dxh = -1; dyh = 0;  end
      default: begin dxh = 0; dyh = -1; end
    endcase
    ux  = int'($urandom_range(0, 100)) - 50;
    uy  = int'($urandom_range(0, 100)) - 50;
    mx  = ux + a*dxh;
    my  = uy + a*dyh;
    p1x = mx - b*dyh;  p1y = my + b*dxh;
    p2x = mx + b*dyh;  p2y = my - b*dxh;
    f = mk(ux, uy, ux + 2*a*dxh, uy + 2*a*dyh, r, r, 0, 0, 1, avg, 0, 0, 1'b0, 1'b0);
    case ($urandom_range(0, 3))
      0: begin f.xw = p1x; f.yw = p1y; f.ex = p1x; f.ey = p1y; end
      1: begin f.xw = p2x; f.yw = p2y; f.ex = p2x; f.ey = p2y; end
      2: begin f.xw = mx; f.yw = my; f.rw = b + 1; f.ex = p2x; f.ey = p2y; f.amb = 1'b1; end
      default: begin
        f.xw = ux - 3*a*dxh; f.yw = uy - 3*a*dyh; f.ex = p1x; f.ey = p1y; f.miss = 1'b1;
      end
    endcase
    return f;
  endfunction

  task automatic model_accept(input frame_t f);
    res_t r;
    r.x = f.ex; r.y = f.ey; r.amb = f.amb; r.miss = f.miss;
    if (!f.avg) begin
      win.delete();
      exp_q.push_back(r);
    end else begin
      win.push_back(r);
      if (win.size() == WIN) begin
        int sx = 0;
        int sy = 0;
        res_t m;
        m.amb = 1'b0; m.miss = 1'b0;
        foreach (win[i]) begin
          sx += win[i].x; sy += win[i].y;
          m.amb  |= win[i].amb;
          m.miss |= win[i].miss;
        end
        m.x = floor_div(sx, WIN);
        m.y = floor_div(sy, WIN);
        exp_q.push_back(m);
        win.delete();
      end
    end
  endtask

  // Entered and left at posedge+1.
  task automatic send(input frame_t f);
    int guard = 0;
    xU = N'(f.xu); yU = N'(f.yu); xV = N'(f.xv); yV = N'(f.yv);
    xW = N'(f.xw); yW = N'(f.yw);
    rU = (N+1)'(f.ru); rV = (N+1)'(f.rv); rW = (N+1)'(f.rw);
    avg_en = f.avg; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) timeout("accept");
    else model_accept(f);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 300) begin
      @(posedge clk);
      g++;
    end
    repeat (3) @(posedge clk);
    #1;
    if (exp_q.size() != 0) timeout("drain");
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_xT"}, xT, 0);
    chk({tag, "_yT"}, yT, 0);
    chk({tag, "_amb"}, amb, 0);
    chk({tag, "_miss"}, miss, 0);
    exp_q.delete();
    win.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: one line per delivered result, hold check while stalled.
  logic signed [N+1:0] prev_x, prev_y;
  logic prev_amb, prev_miss;
  bit   prev_stall = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", in_ready, !(out_valid && !out_ready));
      if (prev_stall) begin
        chk("hold_x", xT, prev_x);
        chk("hold_y", yT, prev_y);
        chk("hold_amb", amb, prev_amb);
        chk("hold_miss", miss, prev_miss);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got (%0d,%0d) amb=%0b miss=%0b, expected none",
                   xT, yT, amb, miss);
        end else begin
          res_t r;
          r = exp_q.pop_front();
          $display("out #%0d: (%0d,%0d) amb=%0b miss=%0b, expected (%0d,%0d) amb=%0b miss=%0b",
                   n_out, xT, yT, amb, miss, r.x, r.y, r.amb, r.miss);
          chk("out_x", xT, r.x);
          chk("out_y", yT, r.y);
          chk("out_amb", amb, r.amb);
          chk("out_miss", miss, r.miss);
        end
        n_out++;
      end
      prev_stall = out_valid && !out_ready;
      prev_x = xT; prev_y = yT; prev_amb = amb; prev_miss = miss;
    end else begin
      prev_stall = 1'b0;
    end
  end

  always begin
    @(posedge clk); #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, g;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; avg_en = 1'b0;
    xU = '0; yU = '0; xV = '0; yV = '0; xW = '0; yW = '0; rU = '0; rV = '0; rW = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_xT", xT, 0);
    chk("rst_yT", yT, 0);
    chk("rst_amb", amb, 0);
    chk("rst_miss", miss, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // pass-through with latency check
    send(mk(0, 0, 6, 0, 5, 5, 3, 4, 1, 1'b0, 3, 4, 1'b0, 1'b0));
    repeat (2) @(posedge clk);
    #1;
    chk("latency_edge3", out_valid, 0);
    @(posedge clk); #1;
    chk("latency_edge4", out_valid, 1);
    send(mk(0, 0, 6, 0, 5, 5, 3, -4, 1, 1'b0, 3, -4, 1'b0, 1'b0));
    send(mk(0, 0, 6, 0, 5, 5, 3, 0, 5, 1'b0, 3, -4, 1'b1, 1'b0));
    send(mk(0, 0, 6, 0, 5, 5, -20, -20, 1, 1'b0, 3, 4, 1'b0, 1'b1));
    drain();

    // averaging windows: (3,4),(3,4),(4,4),(4,5) -> (3,4); negatives -> (-4,-4)
    n0 = n_out;
    send(mk(0, 0, 6, 0, 5, 5, 3, 4, 1, 1'b1, 3, 4, 1'b0, 1'b0));
    send(mk(0, 0, 6, 0, 5, 5, 3, 4, 1, 1'b1, 3, 4, 1'b0, 1'b0));
    send(mk(1, 0, 7, 0, 5, 5, 4, 4, 1, 1'b1, 4, 4, 1'b0, 1'b0));
    send(mk(1, 1, 7, 1, 5, 5, 4, 5, 1, 1'b1, 4, 5, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++)
      send(mk(-6, -7, 0, -7, 5, 5, -3, -3, 1, 1'b1, -3, -3, 1'b0, 1'b0));
    send(mk(-7, -8, -1, -8, 5, 5, -4, -4, 1, 1'b1, -4, -4, 1'b0, 1'b0));
    drain();
    chk("avg_output_count", n_out - n0, 2);

    // avg_en drops mid-window: only the pass-through frame comes out
    n0 = n_out;
    send(rnd_frame(1'b1));
    send(rnd_frame(1'b1));
    send(rnd_frame(1'b0));
    drain();
    chk("avgdrop_output_count", n_out - n0, 1);

    // backpressure: out_ready low for cycles 5-8
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 6; i++) send(rnd_frame(1'b0));
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_output_count", n_out - n0, 6);

    // randomized traffic with random backpressure and idle gaps
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
      send(rnd_frame($urandom_range(0, 9) < 8));
    end
    drain();
    rand_ready = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;

    // reset mid-window, then a fresh window
    send(rnd_frame(1'b1));
    send(rnd_frame(1'b1));
    repeat (6) @(posedge clk);
    #1;
    async_reset("rst_window");
    n0 = n_out;
    for (int i = 0; i < WIN; i++) send(rnd_frame(1'b1));
    drain();
    chk("fresh_window_count", n_out - n0, 1);

    // reset while a result is stalled
    out_ready = 1'b0;
    send(rnd_frame(1'b0));
    g = 0;
    while (!out_valid && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    if (!out_valid) timeout("stall_wait");
    async_reset("rst_stall");
    out_ready = 1'b1;
    n0 = n_out;
    for (int i = 0; i < WIN; i++) send(rnd_frame(1'b1));
    drain();
    chk("post_reset_count", n_out - n0, 1);
    chk("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
